// File: rtl/ttt_pkg.sv
// Shared definitions for the 3x3 board store: cell codes, board packing
// and the turn-sequencing FSM states.
package ttt_pkg;

    localparam int unsigned NUM_CELLS = 9;
    localparam int unsigned POS_W     = 2 * NUM_CELLS;

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_PL    = 2'b01;
    localparam logic [1:0] CELL_PL2   = 2'b10;

    typedef enum logic [1:0] {
        WAIT_PL,
        WAIT_PL2,
        DONE
    } state_t;

    // Extract the 2-bit code of 0-based cell idx from a packed board.
    function automatic logic [1:0] cell_code(input logic [POS_W-1:0] board,
                                             input int unsigned idx);
        return board[2*idx +: 2];
    endfunction

endpackage

// File: rtl/cell_decoder.sv
// Decodes a 1-based board position (1..9) into a one-hot cell select.
// range_ok is low for positions 0 and 10..15; the one-hot is then all zero.
module cell_decoder
    import ttt_pkg::*;
(
    input  logic [3:0]           pos,
    output logic [NUM_CELLS-1:0] onehot,
    output logic                 range_ok
);

    // Range check and one-hot decode of the position.
    always_comb begin
        onehot   = '0;
        range_ok = (pos >= 4'd1) && (pos <= 4'd9);
        if (range_ok) begin
            onehot = 9'(1) << (pos - 4'd1);
        end
    end

endmodule

// File: rtl/move_controller.sv
// Turn-sequencing FSM for the 3x3 board store. Validates player / player2
// move requests, drives the one-hot write enables and illegal_move pulse,
// and freezes once the game is over or the board is full.
// Optional macro TURN_TIMEOUT_EN adds a per-turn idle forfeit after
// TIMEOUT_CYCLES cycles; without it timeout is tied low.
module move_controller
    import ttt_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 play,
    input  logic                 pc,
    input  logic [3:0]           player_pos,
    input  logic [3:0]           pc_pos,
    input  logic [POS_W-1:0]     pos_state,
    input  logic                 game_over,
    output logic [NUM_CELLS-1:0] PL_en,
    output logic [NUM_CELLS-1:0] PL2_en,
    output logic                 illegal_move,
    output logic                 turn,
    output logic [3:0]           move_count,
    output logic                 done,
    output logic                 timeout
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    state_t                 state, state_n;
    logic                   turn_n;
    logic [3:0]             count_n;
    logic [NUM_CELLS-1:0]   claimed, claimed_n;
    logic [NUM_CELLS-1:0]   pl_en_n, pl2_en_n;
    logic                   illegal_n;
    logic [NUM_CELLS-1:0]   occupied;
    logic [NUM_CELLS-1:0]   pl_hot, pc_hot, sel_hot;
    logic                   pl_ok, pc_ok, sel_ok, req, accept;

    cell_decoder u_pl_dec (
        .pos      (player_pos),
        .onehot   (pl_hot),
        .range_ok (pl_ok)
    );

    cell_decoder u_pc_dec (
        .pos      (pc_pos),
        .onehot   (pc_hot),
        .range_ok (pc_ok)
    );

    // A cell is taken if the board shows it or this block already granted it
    // (the claimed mask bridges the cycle before pos_state catches up).
    always_comb begin
        occupied = '0;
        for (int unsigned k = 0; k < NUM_CELLS; k++) begin
            occupied[k] = (cell_code(pos_state, k) != CELL_EMPTY) | claimed[k];
        end
    end

`ifdef TURN_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt, tcnt_n;
    logic          timeout_n;
`endif

    // Next-state, acceptance and output decisions for the side on turn.
    always_comb begin
        state_n   = state;
        turn_n    = turn;
        count_n   = move_count;
        claimed_n = claimed;
        pl_en_n   = '0;
        pl2_en_n  = '0;
        illegal_n = 1'b0;
        accept    = 1'b0;
`ifdef TURN_TIMEOUT_EN
        tcnt_n    = tcnt;
        timeout_n = 1'b0;
`endif
        req     = (state == WAIT_PL2) ? pc     : play;
        sel_hot = (state == WAIT_PL2) ? pc_hot : pl_hot;
        sel_ok  = (state == WAIT_PL2) ? pc_ok  : pl_ok;

        case (state)
            WAIT_PL, WAIT_PL2: begin
                if (game_over) begin
                    state_n = DONE;
                end else begin
                    if (req) begin
                        if (sel_ok && ((sel_hot & occupied) == '0)) begin
                            accept = 1'b1;
                        end else begin
                            illegal_n = 1'b1;
                        end
                    end
                    if (accept) begin
                        if (state == WAIT_PL) pl_en_n  = sel_hot;
                        else                  pl2_en_n = sel_hot;
                        claimed_n = claimed | sel_hot;
                        count_n   = (move_count == 4'd9) ? 4'd9 : move_count + 4'd1;
                        turn_n    = ~turn;
                        if (count_n == 4'd9)        state_n = DONE;
                        else if (state == WAIT_PL)  state_n = WAIT_PL2;
                        else                        state_n = WAIT_PL;
                    end
`ifdef TURN_TIMEOUT_EN
                    if (accept) begin
                        tcnt_n = '0;
                    end else if (tcnt == T_LAST) begin
                        timeout_n = 1'b1;
                        turn_n    = ~turn;
                        tcnt_n    = '0;
                        state_n   = (state == WAIT_PL) ? WAIT_PL2 : WAIT_PL;
                    end else begin
                        tcnt_n = tcnt + TW'(1);
                    end
`endif
                end
            end
            DONE: ;
            default: state_n = WAIT_PL;
        endcase
    end

    // State and registered outputs; synchronous reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= WAIT_PL;
            turn         <= 1'b0;
            move_count   <= '0;
            claimed      <= '0;
            PL_en        <= '0;
            PL2_en       <= '0;
            illegal_move <= 1'b0;
        end else begin
            state        <= state_n;
            turn         <= turn_n;
            move_count   <= count_n;
            claimed      <= claimed_n;
            PL_en        <= pl_en_n;
            PL2_en       <= pl2_en_n;
            illegal_move <= illegal_n;
        end
    end

`ifdef TURN_TIMEOUT_EN
    // Idle counter and forfeit pulse register.
    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= tcnt_n;
            timeout <= timeout_n;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign done = (state == DONE);

endmodule

// File: tb/tb_move_controller.sv
// Self-checking bench for move_controller. A behavioural game model (board
// array, move tally, whose-turn flag) predicts every output; the driven
// pos_state lags the model board like the downstream register bank does.
`timescale 1ns/1ps
module tb_move_controller;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        play = 1'b0, pc = 1'b0, game_over = 1'b0;
    logic [3:0]  player_pos = '0, pc_pos = '0;
    logic [17:0] pos_state = '0;
    logic [8:0]  PL_en, PL2_en;
    logic        illegal_move, turn, done, timeout;
    logic [3:0]  move_count;

    int tests = 0;
    int fails = 0;

    // Reference model
    int   m_board [9];
    int   m_prev  [9];
    int   m_turn, m_moves, m_tc;
    bit   m_done;
    logic [8:0] exp_pl, exp_pl2;
    logic       exp_ill, exp_to;

    move_controller #(.TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .reset        (reset),
        .play         (play),
        .pc           (pc),
        .player_pos   (player_pos),
        .pc_pos       (pc_pos),
        .pos_state    (pos_state),
        .game_over    (game_over),
        .PL_en        (PL_en),
        .PL2_en       (PL2_en),
        .illegal_move (illegal_move),
        .turn         (turn),
        .move_count   (move_count),
        .done         (done),
        .timeout      (timeout)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        for (int i = 0; i < 9; i++) begin
            m_board[i] = 0;
            m_prev[i]  = 0;
        end
        m_turn = 0; m_moves = 0; m_tc = 0; m_done = 0;
        exp_pl = '0; exp_pl2 = '0; exp_ill = 0; exp_to = 0;
    endtask

    task automatic idle_inputs();
        play = 0; pc = 0; game_over = 0; player_pos = '0; pc_pos = '0;
    endtask

    task automatic do_reset();
        reset = 1; idle_inputs();
        @(posedge clock); #1;
        reset = 0;
        model_reset();
    endtask

    // One clock: present the lagged board, predict, advance, settle.
    task automatic cycle();
        int  p;
        bit  rq, acc;
        for (int i = 0; i < 9; i++) pos_state[2*i +: 2] = 2'(m_prev[i]);
        for (int i = 0; i < 9; i++) m_prev[i] = m_board[i];
        exp_pl = '0; exp_pl2 = '0; exp_ill = 0; exp_to = 0;
        acc = 0;
        if (!m_done) begin
            if (game_over) begin
                m_done = 1;
            end else begin
                rq = m_turn ? pc : play;
                p  = m_turn ? int'(pc_pos) : int'(player_pos);
                if (rq) begin
                    if (p >= 1 && p <= 9 && m_board[p-1] == 0) begin
                        acc = 1;
                        m_board[p-1] = m_turn + 1;
                        if (m_turn != 0) exp_pl2[p-1] = 1'b1;
                        else             exp_pl[p-1]  = 1'b1;
                        m_moves++;
                        m_turn = 1 - m_turn;
                        if (m_moves == 9) m_done = 1;
                    end else begin
                        exp_ill = 1;
                    end
                end
`ifdef TURN_TIMEOUT_EN
                if (acc) m_tc = 0;
                else if (m_tc == TO - 1) begin
                    exp_to = 1; m_turn = 1 - m_turn; m_tc = 0;
                end else m_tc++;
`endif
            end
        end
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({PL_en, PL2_en, illegal_move, turn, move_count, done, timeout} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got PL=%b PL2=%b ill=%b turn=%b cnt=%0d done=%b to=%b want all 0",
                     PL_en, PL2_en, illegal_move, turn, move_count, done, timeout);
        end
    endtask

    task automatic test_plan_sequence();
        do_reset();
        play = 1; player_pos = 4'd5;
        cycle();
        play = 0;
        tests++;
        if (PL_en !== 9'b000010000 || turn !== 1'b1 || move_count !== 4'd1 || illegal_move !== 1'b0) begin
            fails++;
            $display("FAIL first_move got PL=%b turn=%b cnt=%0d ill=%b want 000010000 1 1 0",
                     PL_en, turn, move_count, illegal_move);
        end
        pc = 1; pc_pos = 4'd5;
        cycle();
        tests++;
        if (illegal_move !== 1'b1 || PL2_en !== 9'b0 || turn !== 1'b1) begin
            fails++;
            $display("FAIL claimed_lag got ill=%b PL2=%b turn=%b want 1 0 1", illegal_move, PL2_en, turn);
        end
        play = 1; player_pos = 4'd7; pc = 1; pc_pos = 4'd3;
        cycle();
        play = 0; pc = 0;
        tests++;
        if (PL2_en !== 9'b000000100 || PL_en !== 9'b0 || illegal_move !== 1'b0) begin
            fails++;
            $display("FAIL simultaneous got PL2=%b PL=%b ill=%b want 000000100 0 0", PL2_en, PL_en, illegal_move);
        end
    endtask

    // Continues from test_plan_sequence: player to move, two moves made.
    task automatic test_illegal_range();
        logic [3:0] bad [2];
        bad[0] = 4'd0; bad[1] = 4'd10;
        for (int i = 0; i < 2; i++) begin
            play = 1; player_pos = bad[i];
            cycle();
            tests++;
            if (illegal_move !== 1'b1 || PL_en !== 9'b0 || turn !== 1'b0 || move_count !== 4'd2) begin
                fails++;
                $display("FAIL range_%0d got ill=%b PL=%b turn=%b cnt=%0d want 1 0 0 2",
                         bad[i], illegal_move, PL_en, turn, move_count);
            end
        end
        play = 0;
        cycle();
        tests++;
        if (illegal_move !== 1'b0) begin
            fails++;
            $display("FAIL illegal_one_cycle got ill=%b want 0", illegal_move);
        end
    endtask

    task automatic test_full_game();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            play = (k % 2 == 0); pc = (k % 2 == 1);
            player_pos = 4'(k + 1); pc_pos = 4'(k + 1);
            cycle();
            tests++;
            if (PL_en !== exp_pl || PL2_en !== exp_pl2 || move_count !== 4'(k + 1) || done !== (k == 8)) begin
                fails++;
                $display("FAIL full_move_%0d got PL=%b PL2=%b cnt=%0d done=%b want %b %b %0d %b",
                         k, PL_en, PL2_en, move_count, done, exp_pl, exp_pl2, k + 1, k == 8);
            end
        end
        for (int c = 0; c < 5; c++) begin
            play = 1; pc = 1;
            player_pos = 4'($urandom_range(0, 15)); pc_pos = 4'($urandom_range(0, 15));
            cycle();
            tests++;
            if (PL_en !== 9'b0 || PL2_en !== 9'b0 || illegal_move !== 1'b0 || done !== 1'b1 || move_count !== 4'd9) begin
                fails++;
                $display("FAIL frozen_%0d got PL=%b PL2=%b ill=%b done=%b cnt=%0d want 0 0 0 1 9",
                         c, PL_en, PL2_en, illegal_move, done, move_count);
            end
        end
        idle_inputs();
    endtask

    task automatic test_game_over();
        do_reset();
        game_over = 1; play = 1; player_pos = 4'd5;
        cycle();
        game_over = 0;
        tests++;
        if (PL_en !== 9'b0 || illegal_move !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL game_over_priority got PL=%b ill=%b done=%b want 0 0 1", PL_en, illegal_move, done);
        end
        cycle();
        tests++;
        if (PL_en !== 9'b0 || done !== 1'b1 || move_count !== 4'd0) begin
            fails++;
            $display("FAIL game_over_frozen got PL=%b done=%b cnt=%0d want 0 1 0", PL_en, done, move_count);
        end
        idle_inputs();
    endtask

    task automatic test_reset_midgame();
        do_reset();
        play = 1; player_pos = 4'd1; cycle();
        play = 0; pc = 1; pc_pos = 4'd2; cycle();
        pc = 0; play = 1; player_pos = 4'd9;
        reset = 1;
        @(posedge clock); #1;
        reset = 0; idle_inputs(); model_reset();
        tests++;
        if ({PL_en, PL2_en, illegal_move, turn, move_count, done, timeout} !== '0) begin
            fails++;
            $display("FAIL reset_midgame got PL=%b PL2=%b ill=%b turn=%b cnt=%0d done=%b to=%b want all 0",
                     PL_en, PL2_en, illegal_move, turn, move_count, done, timeout);
        end
    endtask

`ifdef TURN_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        for (int c = 1; c <= TO; c++) begin
            cycle();
            tests++;
            if (timeout !== (c == TO)) begin
                fails++;
                $display("FAIL timeout_cycle_%0d got %b want %b", c, timeout, c == TO);
            end
        end
        tests++;
        if (turn !== 1'b1 || move_count !== 4'd0) begin
            fails++;
            $display("FAIL timeout_flip got turn=%b cnt=%0d want 1 0", turn, move_count);
        end
    endtask
`endif

    task automatic test_random();
        for (int g = 0; g < 8; g++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                play = 1'($urandom_range(0, 1)); pc = 1'($urandom_range(0, 1));
                player_pos = 4'($urandom_range(0, 11)); pc_pos = 4'($urandom_range(0, 11));
                game_over = ($urandom_range(0, 59) == 0);
                cycle();
                tests++;
                if (PL_en !== exp_pl || PL2_en !== exp_pl2 || illegal_move !== exp_ill ||
                    move_count !== 4'(m_moves) || done !== m_done || timeout !== exp_to ||
                    (!m_done && turn !== m_turn[0])) begin
                    fails++;
                    $display("FAIL random_g%0d_c%0d got PL=%b PL2=%b ill=%b cnt=%0d done=%b to=%b turn=%b want %b %b %b %0d %b %b %0d",
                             g, c, PL_en, PL2_en, illegal_move, move_count, done, timeout, turn,
                             exp_pl, exp_pl2, exp_ill, m_moves, m_done, exp_to, m_turn);
                end
            end
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plan_sequence();
        test_illegal_range();
        test_full_game();
        test_game_over();
        test_reset_midgame();
`ifdef TURN_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/move_controller.md
Name: move_controller

Overview:
- Turn-sequencing FSM for the 3x3 board store.
- Accepts move requests from the human player and player2, checks that the target cell is legal, and alternates turns.
- Drives the per-cell one-hot write enables (PL_en, PL2_en) and the illegal_move flag consumed by the position register bank.
- Freezes the board once the game ends (win reported externally, or board full).

Parameters:
- TIMEOUT_CYCLES, 1000, clock cycles a side may idle before forfeiting its turn. Used only with TURN_TIMEOUT_EN.

Ports:
- clock  in  1  game clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- play  in  1  player move request, level-sampled each cycle.
- pc  in  1  player2 move request, level-sampled each cycle.
- player_pos  in  4  player target cell, 1..9.
- pc_pos  in  4  player2 target cell, 1..9.
- pos_state  in  18  current board. Cell k occupies bits [2k-1:2k-2]; 00 empty, 01 player, 10 player2.
- game_over  in  1  win detected by the downstream winner logic.
- PL_en  out  9  one-hot player write enable; bit k-1 selects cell k.
- PL2_en  out  9  one-hot player2 write enable, same mapping.
- illegal_move  out  1  one-cycle pulse on a rejected request.
- turn  out  1  0 = player to move, 1 = player2 to move.
- move_count  out  4  accepted moves since reset, 0..9.
- done  out  1  high in DONE state.
- timeout  out  1  one-cycle forfeit pulse; tied 0 without TURN_TIMEOUT_EN.

Behaviour:
- Reset (synchronous; overrides everything, including mid-game):
  - state = WAIT_PL, turn = 0, move_count = 0, claimed mask = 0.
  - PL_en, PL2_en = 0; illegal_move, done, timeout = 0.
- All outputs are registered. An enable or illegal pulse appears exactly 1 cycle after the sampling edge and lasts exactly 1 cycle.
- Occupancy of cell k = (pos_state field k != 00) OR claimed[k].
  - claimed is an internal 9-bit mask, set on the same edge that asserts the enable.
  - It covers the 1-cycle lag before pos_state reflects the write.
- State WAIT_PL (turn = 0):
  - play = 1, player_pos in 1..9, cell free: PL_en one-hot; claimed set; move_count +1; go to WAIT_PL2.
  - play = 1, player_pos = 0 or > 9, or cell occupied: illegal_move = 1, enables 0, stay.
  - play = 0: nothing.
  - pc is ignored (no illegal pulse).
- State WAIT_PL2 (turn = 1): mirror of WAIT_PL, using pc / pc_pos / PL2_en; accepted move returns to WAIT_PL.
- Simultaneous play and pc: only the side whose turn it is is evaluated.
- Held request: after acceptance the turn flips, so the held line is ignored. It is evaluated again only when its turn returns, which may yield an illegal pulse if the cell is now taken.
- DONE entry:
  - Taken on the edge after game_over = 1, from any play state.
  - Also taken when an acceptance makes move_count = 9.
  - game_over takes priority over a same-cycle request: the request is dropped, no enable, no illegal pulse.
- DONE state:
  - done = 1; all requests ignored; enables and illegal_move held 0; move_count frozen.
  - Exit only via reset.
- illegal_move and any enable are never high together.
- move_count saturates at 9.

Optional Feature:
- Macro: TURN_TIMEOUT_EN.
- Defined:
  - A counter clears on every turn change and on reset, and increments each cycle in WAIT_PL / WAIT_PL2.
  - When the counter reaches TIMEOUT_CYCLES - 1 with no acceptance in that cycle: timeout pulses 1 cycle, turn flips, counter clears, move_count unchanged.
  - An illegal request does not clear the counter.
- Undefined: no counter logic; timeout tied 0; a turn waits indefinitely.

Decomposition:
- Shared package ttt_pkg:
  - Cell codes CELL_EMPTY = 2'b00, CELL_PL = 2'b01, CELL_PL2 = 2'b10.
  - NUM_CELLS = 9.
  - FSM state enum {WAIT_PL, WAIT_PL2, DONE}.
  - pos_state packing width 18.
- One sub-module, cell_decoder: 4-bit position to 9-bit one-hot plus range_ok. Instantiated twice, once per side.

Test Plan:
- Reset, then play = 1, player_pos = 5 for 1 cycle -> PL_en = 9'b000010000 one cycle later; turn = 1; move_count = 1; illegal_move = 0.
- Next cycle pc = 1, pc_pos = 5 (pos_state not yet updated) -> illegal_move pulse, PL2_en = 0, turn stays 1.
- play = 1, pc = 1, pc_pos = 3 in WAIT_PL2 -> only PL2_en = 9'b000000100; no PL_en; no illegal pulse.
- player_pos = 0, then 10 -> two illegal pulses; state, turn and move_count unchanged.
- Nine alternating legal moves -> done = 1 after the 9th; further play/pc produce no enables. game_over = 1 asserted together with play -> DONE, no enable.
- With TURN_TIMEOUT_EN, TIMEOUT_CYCLES = 4: idle in WAIT_PL -> timeout pulse after 4 cycles, turn = 1, move_count = 0. Reset asserted mid-game -> all outputs 0 on the next edge.
